// File: rtl/fifo_sync_bytepack.sv
// Single-clock byte-granular width-converting FIFO with variable-length writes/reads and show-ahead output.
// Optional feature macro: FIFO_BYTEPACK_ERR_STICKY_EN (sticky ovf/udf until flush or reset).
module fifo_sync_bytepack #(
    parameter int DW_W   = 64,
    parameter int DW_R   = 32,
    parameter int SIZE   = 2048,
    parameter int AF_LVL = SIZE - (DW_W + 7) / 8,
    parameter int AE_LVL = (DW_R + 7) / 8,
    localparam int DW_W_BYTE = (DW_W + 7) / 8,
    localparam int DW_R_BYTE = (DW_R + 7) / 8,
    localparam int PTR_W     = $clog2(SIZE),
    localparam int NBW_W     = $clog2(DW_W_BYTE + 1),
    localparam int NBR_W     = $clog2(DW_R_BYTE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             w_req,
    input  logic [NBW_W-1:0] w_nbytes,
    input  logic [DW_W-1:0]  data_i,
    input  logic             r_req,
    input  logic [NBR_W-1:0] r_nbytes,
    output logic [DW_R-1:0]  data_o,
    output logic [PTR_W:0]   byte_cnt,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic             ovf,
    output logic             udf
);

    localparam int CW = PTR_W + 1;
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] WB_C   = CW'(DW_W_BYTE);
    localparam logic [CW-1:0] RB_C   = CW'(DW_R_BYTE);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LVL);

    logic [7:0]       mem_q [SIZE];
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [CW-1:0]    wn, rn, free_b;
    logic             wacc, racc, wrej, rrej;
    logic [DW_W_BYTE*8-1:0] wdata_pad;
    logic [DW_R_BYTE*8-1:0] rdata_pad;

    // Request semantics: w_req/r_req are sampled every cycle with no ready back-pressure;
    // a request with a nonzero byte count either completes in that cycle (acc) or is
    // dropped and reported on ovf/udf. Both sides are judged against the pre-cycle count.
    always_comb begin
        wn     = CW'(w_nbytes);
        rn     = CW'(r_nbytes);
        free_b = SIZE_C - cnt_q;
        wacc   = w_req && (wn != '0) && (wn <= WB_C) && (wn <= free_b);
        racc   = r_req && (rn != '0) && (rn <= RB_C) && (rn <= cnt_q);
        wrej   = w_req && (wn != '0) && !wacc;
        rrej   = r_req && (rn != '0) && !racc;
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wacc) w_ptr_d = w_ptr_q + PTR_W'(wn);
            if (racc) r_ptr_d = r_ptr_q + PTR_W'(rn);
            cnt_d = cnt_q + (wacc ? wn : '0) - (racc ? rn : '0);
`ifdef FIFO_BYTEPACK_ERR_STICKY_EN
            ovf_d = ovf_q | wrej;
            udf_d = udf_q | rrej;
`else
            ovf_d = wrej;
            udf_d = rrej;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wdata_pad = (DW_W_BYTE * 8)'(data_i);

    // Storage is not reset; lanes beyond w_nbytes leave their bytes untouched.
    always_ff @(posedge clk) begin
        if (wacc && !flush) begin
            for (int i = 0; i < DW_W_BYTE; i++) begin
                if (CW'(i) < wn) begin
                    mem_q[PTR_W'(w_ptr_q + PTR_W'(i))] <= wdata_pad[8*i +: 8];
                end
            end
        end
    end

    // Show-ahead: lanes past the stored byte count read as zero.
    always_comb begin
        rdata_pad = '0;
        for (int i = 0; i < DW_R_BYTE; i++) begin
            if (CW'(i) < cnt_q) begin
                rdata_pad[8*i +: 8] = mem_q[PTR_W'(r_ptr_q + PTR_W'(i))];
            end
        end
    end

    assign data_o   = rdata_pad[DW_R-1:0];
    assign byte_cnt = cnt_q;
    assign full     = free_b < WB_C;
    assign empty    = cnt_q == '0;
    assign afull    = cnt_q >= AF_C;
    assign aempty   = cnt_q <= AE_C;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_fifo_sync_bytepack.sv
// Directed plus random bench for fifo_sync_bytepack (DW_W=64, DW_R=32, SIZE=64, AF=56, AE=4).
module tb_fifo_sync_bytepack;

    localparam int DW_W = 64;
    localparam int DW_R = 32;
    localparam int SIZE = 64;
    localparam int AF   = 56;
    localparam int AE   = 4;
    localparam int WB   = 8;
    localparam int RB   = 4;
    localparam int EW   = 32 + 7 + 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        w_req = 1'b0;
    logic [3:0]  w_nbytes = '0;
    logic [63:0] data_i = '0;
    logic        r_req = 1'b0;
    logic [2:0]  r_nbytes = '0;
    logic [31:0] data_o;
    logic [6:0]  byte_cnt;
    logic        full, empty, afull, aempty, ovf, udf;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    mdl[$];
    logic          ovf_m = 1'b0;
    logic          udf_m = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [7:0]    seq_b = 8'h00;

    fifo_sync_bytepack #(
        .DW_W(DW_W), .DW_R(DW_R), .SIZE(SIZE), .AF_LVL(AF), .AE_LVL(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .w_req(w_req), .w_nbytes(w_nbytes), .data_i(data_i),
        .r_req(r_req), .r_nbytes(r_nbytes), .data_o(data_o),
        .byte_cnt(byte_cnt), .full(full), .empty(empty), .afull(afull),
        .aempty(aempty), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the byte-queue model, push expected outputs, then pop and compare.
    task automatic step(input logic wr, input int wn, input logic [63:0] wd,
                        input logic rd, input int rn, input logic fl);
        logic wacc, racc, wrej, rrej;
        logic [31:0] ed;
        logic [EW-1:0] e;
        int cnt;
        w_req = wr; w_nbytes = 4'(wn); data_i = wd;
        r_req = rd; r_nbytes = 3'(rn); flush = fl;
        cnt  = mdl.size();
        wacc = wr && wn != 0 && wn <= WB && wn <= SIZE - cnt;
        racc = rd && rn != 0 && rn <= RB && rn <= cnt;
        wrej = wr && wn != 0 && !wacc;
        rrej = rd && rn != 0 && !racc;
        if (fl) begin
            mdl.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            if (racc) for (int i = 0; i < rn; i++) void'(mdl.pop_front());
            if (wacc) for (int i = 0; i < wn; i++) mdl.push_back(wd[8*i +: 8]);
`ifdef FIFO_BYTEPACK_ERR_STICKY_EN
            ovf_m = ovf_m | wrej;
            udf_m = udf_m | rrej;
`else
            ovf_m = wrej;
            udf_m = rrej;
`endif
        end
        cnt = mdl.size();
        ed = '0;
        for (int i = 0; i < RB; i++) if (i < cnt) ed[8*i +: 8] = mdl[i];
        exp_q.push_back({ed, 7'(cnt), (SIZE - cnt) < WB, cnt == 0, cnt >= AF, cnt <= AE, ovf_m, udf_m});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("data_o", 64'(data_o), 64'(e[44:13]));
        chk("byte_cnt", 64'(byte_cnt), 64'(e[12:6]));
        chk("flags", 64'({full, empty, afull, aempty}), 64'(e[5:2]));
        chk("ovf", 64'(ovf), 64'(e[1]));
        chk("udf", 64'(udf), 64'(e[0]));
        w_req = 1'b0; r_req = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [63:0] seq_word();
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = seq_b;
            seq_b = seq_b + 8'd1;
        end
        return w;
    endfunction

    initial begin
        // Reset
        #23;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_aempty", 64'(aempty), 64'd1);
        chk("rst_cnt", 64'(byte_cnt), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_full_afull", 64'({full, afull}), 64'd0);
        chk("rst_err", 64'({ovf, udf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read with show-ahead
        step(1, 8, 64'h0807060504030201, 0, 0, 0);
        chk("t2_data", 64'(data_o), 64'h04030201);
        chk("t2_cnt", 64'(byte_cnt), 64'd8);
        step(0, 0, '0, 1, 4, 0);
        chk("t2_data_rd", 64'(data_o), 64'h08070605);
        chk("t2_aempty", 64'(aempty), 64'd1);
        step(0, 0, '0, 1, 4, 0);

        // Partial write, zero-masked lanes
        step(1, 3, 64'hFFFFFFFFFFAABBCC, 0, 0, 0);
        chk("t3_data", 64'(data_o), 64'h00AABBCC);
        chk("t3_cnt", 64'(byte_cnt), 64'd3);
        step(0, 0, '0, 1, 3, 0);

        // Zero-length requests are silent no-ops
        step(1, 0, 64'hDEAD, 1, 0, 0);

        // Fill to full, overflow, drain, underflow
        for (int k = 0; k < 8; k++) step(1, 8, seq_word(), 0, 0, 0);
        chk("t4_full", 64'({byte_cnt, full, afull}), {55'd0, 7'd64, 2'b11});
        step(1, 8, 64'h1111111111111111, 0, 0, 0);
        chk("t4_ovf", 64'({byte_cnt, ovf}), {56'd0, 7'd64, 1'b1});
        for (int k = 0; k < 16; k++) step(0, 0, '0, 1, 4, 0);
        step(0, 0, '0, 1, 4, 0);
        chk("t4_udf", 64'(udf), 64'd1);
        step(1, 9, 64'h22, 1, 5, 0);

        // Pointers to 48, fill to 56, concurrent write+read across the wrap
        step(0, 0, '0, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            step(1, 8, seq_word(), 0, 0, 0);
            step(0, 0, '0, 1, 4, 0);
            step(0, 0, '0, 1, 4, 0);
        end
        for (int k = 0; k < 7; k++) step(1, 8, seq_word(), 0, 0, 0);
        chk("t5_afull", 64'({byte_cnt, afull}), {56'd0, 7'd56, 1'b1});
        step(1, 8, seq_word(), 1, 4, 0);
        chk("t5_cnt", 64'(byte_cnt), 64'd60);
        for (int k = 0; k < 15; k++) step(0, 0, '0, 1, 4, 0);
        chk("t5_empty", 64'(empty), 64'd1);

        // Flush beats a same-cycle write and clears the error flag
        step(1, 8, seq_word(), 0, 0, 0);
        step(1, 8, seq_word(), 0, 0, 0);
        step(1, 4, seq_word(), 0, 0, 0);
        step(1, 9, 64'h33, 0, 0, 0);
        chk("t6_ovf", 64'({byte_cnt, ovf}), {56'd0, 7'd20, 1'b1});
        step(1, 8, 64'h4444444444444444, 0, 0, 1);
        chk("t6_flush", 64'({byte_cnt, empty, ovf}), {55'd0, 7'd0, 2'b10});

        // Random mixed traffic
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
